// File: rtl/hood_fan_scheduler_if.sv
// ---------------------------------------------------------------------------
// hood_fan_scheduler_if
// Purpose : bundles the hood-state inputs and the fan/reminder outputs of
//           hood_fan_scheduler into one interface.
// Signals :
//   state           [1:0]  hood state: 00 OFF, 01 STANDBY, 10 SMOKING, 11 CLEANING
//   state_smoke_lvl [3:0]  one-hot smoke level (0001 lvl1, 0010 lvl2, 0100 lvl3)
//   clear_reminder         single-cycle manual clear of runtime and reminder
//   fan_speed       [1:0]  motor command: 0 stop, 1 low, 2 mid, 3 high
//   afterrun_active        high while the after-run is in progress
//   afterrun_left   [7:0]  after-run seconds remaining, 0 otherwise
//   runtime_sec     [15:0] accumulated smoking seconds, saturating
//   clean_reminder         high when runtime_sec >= REMIND_SEC
// Modports: master = hood state machine side (drives inputs),
//           slave  = scheduler side (drives outputs).
// ---------------------------------------------------------------------------
interface hood_fan_scheduler_if;
  logic [1:0]  state;
  logic [3:0]  state_smoke_lvl;
  logic        clear_reminder;
  logic [1:0]  fan_speed;
  logic        afterrun_active;
  logic [7:0]  afterrun_left;
  logic [15:0] runtime_sec;
  logic        clean_reminder;

  modport master (
    output state, state_smoke_lvl, clear_reminder,
    input  fan_speed, afterrun_active, afterrun_left, runtime_sec, clean_reminder
  );

  modport slave (
    input  state, state_smoke_lvl, clear_reminder,
    output fan_speed, afterrun_active, afterrun_left, runtime_sec, clean_reminder
  );
endinterface

// File: rtl/hood_fan_scheduler.sv
// ---------------------------------------------------------------------------
// hood_fan_scheduler
// Purpose : drives the exhaust-fan motor from the hood state machine.
//           Maps smoke level to fan speed, runs a timed after-run when
//           smoking ends, and accumulates smoking runtime to raise a clean
//           reminder that a completed cleaning session or a manual clear
//           resets.
// Ports   :
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    hood_fan_scheduler_if.slave (hood state in, fan/reminder out)
// All outputs are registered: they reflect the inputs sampled at the
// previous clock edge.
// ---------------------------------------------------------------------------
module hood_fan_scheduler #(
  parameter int CLK_PER_SEC  = 100000000,
  parameter int AFTERRUN_SEC = 60,
  parameter int REMIND_SEC   = 36000,
  parameter int CLEAN_SEC    = 180
) (
  input logic                 clk,
  input logic                 reset,
  hood_fan_scheduler_if.slave bus
);

  // Scheduler FSM encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_AFTERRUN = 2'd2;
  localparam logic [1:0] ST_CLEAN    = 2'd3;

  // Hood state codes as delivered by the hood state machine
  localparam logic [1:0] HS_OFF      = 2'b00;
  localparam logic [1:0] HS_STANDBY  = 2'b01;
  localparam logic [1:0] HS_SMOKING  = 2'b10;
  localparam logic [1:0] HS_CLEANING = 2'b11;

  localparam int              PW            = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_MAX     = PW'(CLK_PER_SEC - 1);
  localparam logic [7:0]      AFTERRUN_LOAD = 8'(AFTERRUN_SEC);
  localparam logic [7:0]      CLEAN_TARGET  = 8'(CLEAN_SEC);
  localparam logic [15:0]     REMIND_TH     = 16'(REMIND_SEC);

  logic [1:0]    r_fsm;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_afterrun_left;
  logic [7:0]    r_clean_cnt;
  logic          r_clean_done;
  logic [15:0]   r_runtime;
  logic          r_reminder;
  logic [1:0]    r_fan_speed;
  logic          r_afterrun_active;

  logic [1:0]    w_next_fsm;
  logic          w_state_change;
  logic          w_tick;
  logic          w_tick_eff;
  logic          w_clean_exit_done;
  logic [1:0]    w_run_speed;
  logic [1:0]    w_next_fan;

  assign w_tick         = (r_presc == PRESC_MAX);
  assign w_state_change = (w_next_fsm != r_fsm);
  // A tick coinciding with a state change is dropped; the new state starts
  // its interval from a freshly cleared prescaler.
  assign w_tick_eff     = w_tick && !w_state_change;

  // Leaving CLEAN after a full session wipes the runtime and reminder.
  assign w_clean_exit_done = (r_fsm == ST_CLEAN) && (w_next_fsm != ST_CLEAN) && r_clean_done;

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next_fsm = r_fsm;
    case (r_fsm)
      ST_IDLE: begin
        if (bus.state == HS_SMOKING)       w_next_fsm = ST_RUN;
        else if (bus.state == HS_CLEANING) w_next_fsm = ST_CLEAN;
      end
      ST_RUN: begin
        if (bus.state == HS_STANDBY)       w_next_fsm = ST_AFTERRUN;
        else if (bus.state == HS_CLEANING) w_next_fsm = ST_CLEAN;
      end
      ST_AFTERRUN: begin
        if (bus.state == HS_SMOKING)       w_next_fsm = ST_RUN;
        else if (bus.state == HS_CLEANING) w_next_fsm = ST_CLEAN;
        else if (w_tick && (r_afterrun_left == 8'd1)) w_next_fsm = ST_IDLE;
      end
      ST_CLEAN: begin
        if (bus.state == HS_SMOKING)        w_next_fsm = ST_RUN;
        else if (bus.state != HS_CLEANING) w_next_fsm = ST_IDLE;
      end
      default: w_next_fsm = ST_IDLE;
    endcase
    // Power loss overrides everything.
    if (bus.state == HS_OFF) w_next_fsm = ST_IDLE;
  end

  // Level-to-speed map; anything not strictly one of the three levels
  // falls back to low speed so the hood never smokes with the fan stopped.
  always_comb begin
    w_run_speed = 2'd1;
    case (bus.state_smoke_lvl)
      4'b0001: w_run_speed = 2'd1;
      4'b0010: w_run_speed = 2'd2;
      4'b0100: w_run_speed = 2'd3;
      default: w_run_speed = 2'd1;
    endcase
  end

  always_comb begin
    w_next_fan = 2'd0;
    case (w_next_fsm)
      ST_RUN:      w_next_fan = w_run_speed;
      ST_AFTERRUN: w_next_fan = 2'd1;
      default:     w_next_fan = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_fsm             <= ST_IDLE;
      r_presc           <= '0;
      r_afterrun_left   <= 8'd0;
      r_clean_cnt       <= 8'd0;
      r_clean_done      <= 1'b0;
      r_runtime         <= 16'd0;
      r_reminder        <= 1'b0;
      r_fan_speed       <= 2'd0;
      r_afterrun_active <= 1'b0;
    end else begin
      r_fsm <= w_next_fsm;

      if (w_state_change || w_tick) r_presc <= '0;
      else                          r_presc <= r_presc + PW'(1);

      // After-run countdown: loaded on entry, decremented per second; the
      // final second's expiry is handled as a transition to IDLE.
      if (w_next_fsm != ST_AFTERRUN)  r_afterrun_left <= 8'd0;
      else if (r_fsm != ST_AFTERRUN)  r_afterrun_left <= AFTERRUN_LOAD;
      else if (w_tick_eff)            r_afterrun_left <= r_afterrun_left - 8'd1;

      // Clean progress only survives while staying in CLEAN.
      if ((r_fsm == ST_CLEAN) && (w_next_fsm == ST_CLEAN)) begin
        if (w_tick_eff && (r_clean_cnt != CLEAN_TARGET)) begin
          r_clean_cnt <= r_clean_cnt + 8'd1;
          if (r_clean_cnt + 8'd1 == CLEAN_TARGET) r_clean_done <= 1'b1;
        end
      end else begin
        r_clean_cnt  <= 8'd0;
        r_clean_done <= 1'b0;
      end

      if (bus.clear_reminder || w_clean_exit_done)
        r_runtime <= 16'd0;
      else if ((r_fsm == ST_RUN) && w_tick_eff && (r_runtime != 16'hFFFF))
        r_runtime <= r_runtime + 16'd1;

      if (bus.clear_reminder || w_clean_exit_done) r_reminder <= 1'b0;
      else                                         r_reminder <= (r_runtime >= REMIND_TH);

      r_fan_speed       <= w_next_fan;
      r_afterrun_active <= (w_next_fsm == ST_AFTERRUN);
    end
  end

  assign bus.fan_speed       = r_fan_speed;
  assign bus.afterrun_active = r_afterrun_active;
  assign bus.afterrun_left   = r_afterrun_left;
  assign bus.runtime_sec     = r_runtime;
  assign bus.clean_reminder  = r_reminder;

endmodule

// File: tb/tb_hood_fan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hood_fan_scheduler
// Purpose : self-checking bench for hood_fan_scheduler. A vector table covers
//           level mapping and basic transitions; hand-written sequences cover
//           after-run timing, interrupts, reminder, cleaning and reset.
//           A second instance with one-cycle seconds reaches runtime
//           saturation within a short run.
// ---------------------------------------------------------------------------
module tb_hood_fan_scheduler;

  localparam logic [1:0] HS_OFF      = 2'b00;
  localparam logic [1:0] HS_STANDBY  = 2'b01;
  localparam logic [1:0] HS_SMOKING  = 2'b10;
  localparam logic [1:0] HS_CLEANING = 2'b11;

  typedef struct {
    logic [1:0]  fan;
    logic        act;
    logic [7:0]  left;
    logic [15:0] rt;
    logic        rem;
  } exp_t;

  typedef struct {
    logic [1:0]  st;
    logic [3:0]  lvl;
    logic        clr;
    exp_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb_q[$];
  vec_t vecs[14];

  always #5 clk = ~clk;

  hood_fan_scheduler_if bus ();
  hood_fan_scheduler_if bus2 ();

  hood_fan_scheduler #(
    .CLK_PER_SEC(10), .AFTERRUN_SEC(5), .REMIND_SEC(20), .CLEAN_SEC(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // One-cycle seconds so the 16-bit runtime saturates quickly.
  hood_fan_scheduler #(
    .CLK_PER_SEC(1), .AFTERRUN_SEC(5), .REMIND_SEC(65535), .CLEAN_SEC(3)
  ) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  function automatic exp_t mk(input logic [1:0] fan, input logic act,
                              input logic [7:0] left, input logic [15:0] rt,
                              input logic rem);
    exp_t e;
    e.fan = fan; e.act = act; e.left = left; e.rt = rt; e.rem = rem;
    return e;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".fan_speed"},       16'(bus.fan_speed),       16'(e.fan));
    check({tag, ".afterrun_active"}, 16'(bus.afterrun_active), 16'(e.act));
    check({tag, ".afterrun_left"},   16'(bus.afterrun_left),   16'(e.left));
    check({tag, ".runtime_sec"},     bus.runtime_sec,          e.rt);
    check({tag, ".clean_reminder"},  16'(bus.clean_reminder),  16'(e.rem));
  endtask

  // Drive inputs, queue the expectation, run n edges, then compare.
  task automatic apply(input string tag, input logic [1:0] st, input logic [3:0] lvl,
                       input logic clr, input int n, input exp_t e);
    bus.state           = st;
    bus.state_smoke_lvl = lvl;
    bus.clear_reminder  = clr;
    sb_q.push_back(e);
    step(n);
    compare_out(tag);
  endtask

  initial begin
    reset                = 1'b1;
    bus.state            = HS_OFF;
    bus.state_smoke_lvl  = 4'b0000;
    bus.clear_reminder   = 1'b0;
    bus2.state           = HS_OFF;
    bus2.state_smoke_lvl = 4'b0001;
    bus2.clear_reminder  = 1'b0;

    apply("reset", HS_OFF, 4'b0000, 1'b0, 2, mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0));
    reset = 1'b0;

    // Level mapping and basic transitions; RUN stays under one second here.
    vecs[0]  = '{HS_STANDBY,  4'b0001, 1'b0, mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[1]  = '{HS_SMOKING,  4'b0001, 1'b0, mk(2'd1, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[2]  = '{HS_SMOKING,  4'b0010, 1'b0, mk(2'd2, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[3]  = '{HS_SMOKING,  4'b0100, 1'b0, mk(2'd3, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[4]  = '{HS_SMOKING,  4'b0000, 1'b0, mk(2'd1, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[5]  = '{HS_SMOKING,  4'b0110, 1'b0, mk(2'd1, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[6]  = '{HS_SMOKING,  4'b1000, 1'b0, mk(2'd1, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[7]  = '{HS_STANDBY,  4'b0100, 1'b0, mk(2'd1, 1'b1, 8'd5, 16'd0, 1'b0)};
    vecs[8]  = '{HS_OFF,      4'b0100, 1'b0, mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[9]  = '{HS_CLEANING, 4'b0001, 1'b0, mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[10] = '{HS_SMOKING,  4'b0100, 1'b0, mk(2'd3, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[11] = '{HS_CLEANING, 4'b0100, 1'b0, mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[12] = '{HS_STANDBY,  4'b0001, 1'b1, mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0)};
    vecs[13] = '{HS_STANDBY,  4'b0001, 1'b0, mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0)};
    for (int i = 0; i < 14; i++)
      apply($sformatf("vec%0d", i), vecs[i].st, vecs[i].lvl, vecs[i].clr, 1, vecs[i].exp);

    // After-run: 5 s countdown, one second = 10 cycles from entry.
    apply("ar.run",   HS_SMOKING, 4'b0100, 1'b0, 1,  mk(2'd3, 1'b0, 8'd0, 16'd0, 1'b0));
    apply("ar.entry", HS_STANDBY, 4'b0100, 1'b0, 1,  mk(2'd1, 1'b1, 8'd5, 16'd0, 1'b0));
    apply("ar.hold5", HS_STANDBY, 4'b0100, 1'b0, 9,  mk(2'd1, 1'b1, 8'd5, 16'd0, 1'b0));
    apply("ar.4",     HS_STANDBY, 4'b0100, 1'b0, 1,  mk(2'd1, 1'b1, 8'd4, 16'd0, 1'b0));
    apply("ar.3",     HS_STANDBY, 4'b0100, 1'b0, 10, mk(2'd1, 1'b1, 8'd3, 16'd0, 1'b0));
    apply("ar.2",     HS_STANDBY, 4'b0100, 1'b0, 10, mk(2'd1, 1'b1, 8'd2, 16'd0, 1'b0));
    apply("ar.1",     HS_STANDBY, 4'b0100, 1'b0, 10, mk(2'd1, 1'b1, 8'd1, 16'd0, 1'b0));
    apply("ar.last",  HS_STANDBY, 4'b0100, 1'b0, 9,  mk(2'd1, 1'b1, 8'd1, 16'd0, 1'b0));
    apply("ar.done",  HS_STANDBY, 4'b0100, 1'b0, 1,  mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0));
    apply("ar.idle",  HS_STANDBY, 4'b0100, 1'b0, 5,  mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0));

    // After-run interrupted by smoking, then by power loss.
    apply("int.run",    HS_SMOKING, 4'b0010, 1'b0, 1,  mk(2'd2, 1'b0, 8'd0, 16'd0, 1'b0));
    apply("int.ar",     HS_STANDBY, 4'b0010, 1'b0, 1,  mk(2'd1, 1'b1, 8'd5, 16'd0, 1'b0));
    apply("int.at3",    HS_STANDBY, 4'b0010, 1'b0, 20, mk(2'd1, 1'b1, 8'd3, 16'd0, 1'b0));
    apply("int.cancel", HS_SMOKING, 4'b0001, 1'b0, 1,  mk(2'd1, 1'b0, 8'd0, 16'd0, 1'b0));
    apply("int.lvl",    HS_SMOKING, 4'b0100, 1'b0, 1,  mk(2'd3, 1'b0, 8'd0, 16'd0, 1'b0));
    apply("int.ar2",    HS_STANDBY, 4'b0100, 1'b0, 1,  mk(2'd1, 1'b1, 8'd5, 16'd0, 1'b0));
    apply("int.ar2h",   HS_STANDBY, 4'b0100, 1'b0, 15, mk(2'd1, 1'b1, 8'd4, 16'd0, 1'b0));
    apply("int.off",    HS_OFF,     4'b0100, 1'b0, 1,  mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0));

    // Runtime accumulation, reminder and manual clear.
    apply("rm.entry",    HS_SMOKING, 4'b0001, 1'b0, 1,   mk(2'd1, 1'b0, 8'd0, 16'd0,  1'b0));
    apply("rm.19",       HS_SMOKING, 4'b0001, 1'b0, 199, mk(2'd1, 1'b0, 8'd0, 16'd19, 1'b0));
    apply("rm.20",       HS_SMOKING, 4'b0001, 1'b0, 1,   mk(2'd1, 1'b0, 8'd0, 16'd20, 1'b0));
    apply("rm.set",      HS_SMOKING, 4'b0001, 1'b0, 1,   mk(2'd1, 1'b0, 8'd0, 16'd20, 1'b1));
    apply("rm.clr",      HS_SMOKING, 4'b0001, 1'b1, 1,   mk(2'd1, 1'b0, 8'd0, 16'd0,  1'b0));
    apply("rm.pre",      HS_SMOKING, 4'b0001, 1'b0, 7,   mk(2'd1, 1'b0, 8'd0, 16'd0,  1'b0));
    apply("rm.clrtick",  HS_SMOKING, 4'b0001, 1'b1, 1,   mk(2'd1, 1'b0, 8'd0, 16'd0,  1'b0));
    apply("rm.after",    HS_SMOKING, 4'b0001, 1'b0, 10,  mk(2'd1, 1'b0, 8'd0, 16'd1,  1'b0));
    apply("rm.20b",      HS_SMOKING, 4'b0001, 1'b0, 190, mk(2'd1, 1'b0, 8'd0, 16'd20, 1'b0));
    apply("rm.setb",     HS_SMOKING, 4'b0001, 1'b0, 1,   mk(2'd1, 1'b0, 8'd0, 16'd20, 1'b1));

    // Partial clean (two seconds in CLEAN) leaves the reminder alone.
    apply("pc.entry", HS_CLEANING, 4'b0001, 1'b0, 1,  mk(2'd0, 1'b0, 8'd0, 16'd20, 1'b1));
    apply("pc.hold",  HS_CLEANING, 4'b0001, 1'b0, 20, mk(2'd0, 1'b0, 8'd0, 16'd20, 1'b1));
    apply("pc.exit",  HS_SMOKING,  4'b0001, 1'b0, 1,  mk(2'd1, 1'b0, 8'd0, 16'd20, 1'b1));

    // Full clean: 30 cycles in CLEAN, then leaving clears runtime/reminder.
    apply("fc.entry", HS_CLEANING, 4'b0001, 1'b0, 1,  mk(2'd0, 1'b0, 8'd0, 16'd20, 1'b1));
    apply("fc.hold",  HS_CLEANING, 4'b0001, 1'b0, 30, mk(2'd0, 1'b0, 8'd0, 16'd20, 1'b1));
    apply("fc.exit",  HS_STANDBY,  4'b0001, 1'b0, 1,  mk(2'd0, 1'b0, 8'd0, 16'd0,  1'b0));
    apply("fc.idle",  HS_STANDBY,  4'b0001, 1'b0, 2,  mk(2'd0, 1'b0, 8'd0, 16'd0,  1'b0));

    // Reset in the middle of an after-run.
    apply("rs.run", HS_SMOKING, 4'b0010, 1'b0, 15, mk(2'd2, 1'b0, 8'd0, 16'd1, 1'b0));
    apply("rs.ar",  HS_STANDBY, 4'b0010, 1'b0, 1,  mk(2'd1, 1'b1, 8'd5, 16'd1, 1'b0));
    apply("rs.at3", HS_STANDBY, 4'b0010, 1'b0, 20, mk(2'd1, 1'b1, 8'd3, 16'd1, 1'b0));
    reset = 1'b1;
    apply("rs.reset", HS_STANDBY, 4'b0010, 1'b0, 1, mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0));
    reset = 1'b0;
    apply("rs.idle", HS_STANDBY, 4'b0010, 1'b0, 3, mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0));
    apply("rs.run2", HS_SMOKING, 4'b0100, 1'b0, 1, mk(2'd3, 1'b0, 8'd0, 16'd0, 1'b0));
    apply("rs.off",  HS_OFF,     4'b0100, 1'b0, 1, mk(2'd0, 1'b0, 8'd0, 16'd0, 1'b0));

    // Saturation on the one-cycle-second instance: runtime equals the
    // number of edges after RUN entry, capped at 16'hFFFF.
    bus2.state = HS_SMOKING;
    step(65536);
    check("sat.reach",   bus2.runtime_sec, 16'hFFFF);
    check("sat.rem_lag", 16'(bus2.clean_reminder), 16'd0);
    step(1);
    check("sat.rem",     16'(bus2.clean_reminder), 16'd1);
    step(20);
    check("sat.hold",    bus2.runtime_sec, 16'hFFFF);
    check("sat.fan",     16'(bus2.fan_speed), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
